uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised UART receiver. Successor to the fixed 8N1 receiver.
//  Adds the following features:
//   - configurable data width, parity and stop bits;
//   - 2-flop input synchroniser;
//   - oversampled, majority-voted bit sampling;
//   - false-start rejection;
//   - parity and framing error reporting.
//  Sits between the rx pad and the command/packet parser. Delivers one word per vld pulse.
// PARAMETERS
//  FREQ        50_000_000  system clock frequency, Hz
//  BAUDRATE    115200      line rate, bit/s
//  OVERSAMPLE  16          sample ticks per bit; even, >=8
//  DATA_BITS   8           payload bits, 5..9, LSB first on the line
//  PARITY      0           0 none, 1 odd, 2 even (encodings in uart_pkg)
//  STOP_BITS   1           1 or 2
//  SYNC_STAGES 2           rx synchroniser depth, >=2
// PORTS
//  clk         in   1          system clock
//  nrst        in   1          asynchronous active-low reset
//  rx          in   1          serial line, idle high, asynchronous to clk
//  rdata       out  DATA_BITS  received word; valid while vld=1, then holds the value
//  vld         out  1          one-clk pulse per completed frame
//  parity_err  out  1          qualified by vld; parity mismatch (always 0 when PARITY=0)
//  frame_err   out  1          qualified by vld; a stop bit was sampled low
//  busy        out  1          high from start detect until return to IDLE
// BEHAVIOUR
//  - Reset (async, nrst=0): all outputs 0, FSM=IDLE, counters 0, synchroniser flops 1.
//  - Tick: DIV = FREQ/(BAUDRATE*OVERSAMPLE), integer division, elaboration error if DIV<2.
//    Tick counter runs 0..DIV-1 and emits a 1-clk tick at DIV-1.
//    It is cleared on start detect so sampling aligns to the falling edge.
//  - Sampling: a sub-bit counter counts ticks 0..OVERSAMPLE-1.
//    The bit value is the majority of the synchronised rx at sub-counts OS/2-1, OS/2 and OS/2+1.
//    The decision is made at tick OS/2+1.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> (IDLE | BREAK)
//    - IDLE:   synchronised rx=0 -> START; busy rises on the next clk.
//    - START:  voted 0 -> DATA. Voted 1 -> false start, IDLE, no vld.
//    - DATA:   shift the voted bit into rdata_sh[bit_cnt], bit_cnt 0..DATA_BITS-1.
//              At the last bit go to PARITY if PARITY!=0, else STOP.
//    - PARITY: compute the expected bit.
//              Odd: ~^data. Even: ^data.
//              perr latched when voted != expected.
//    - STOP:   sample STOP_BITS bits; ferr latched if any is voted 0.
//              At the final stop-bit decision the FSM leaves STOP. On the next clk:
//               - vld=1;
//               - rdata=rdata_sh;
//               - parity_err=perr;
//               - frame_err=ferr.
//              It then goes to IDLE if the voted bit is 1, else to BREAK.
//              It does not wait for the bit end; the early return absorbs up to 1/2 bit of rate mismatch.
//    - BREAK:  wait until synchronised rx=1, then go to IDLE. Prevents re-trigger on a held-low line.
//  - vld is exactly 1 clk wide.
//    rdata, parity_err and frame_err hold their values until the next vld; they are not zeroed.
//  - A frame is delivered even when erroneous; errors are flags only.
//  - Latency: rx edge to the start sample sees SYNC_STAGES clks of synchroniser delay.
//    vld follows the final stop-bit decision by 1 clk.
//  - Mid-frame rx glitches shorter than 1 tick are suppressed by the majority vote.
//  - Reset mid-frame: immediate abort. No vld; the partial word is discarded.
//  - Widths: bit_cnt is $clog2(DATA_BITS+1) bits, sub-counter $clog2(OVERSAMPLE) bits, tick counter $clog2(DIV) bits.
//    No counter wraps except through an explicit clear.
// STRUCTURE
//  - uart_pkg: parity encodings PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2; FSM state encoding; majority3 function.
//  - Sub-module uart_baud_tick (DIV, clear input, tick output). It will be reused by the matching transmitter.
//  - Synchroniser, FSM and shifter stay inline in uart_rx_cfg.
// TESTING
//  Sim params: FREQ=16_000_000, BAUDRATE=500_000, OVERSAMPLE=16, so DIV=2 and 32 clk/bit.
//  1. 8N1: send 0x55 then 0xA3 back-to-back -> two vld pulses, rdata=0x55 then 0xA3, both errs 0.
//  2. 8E1: 0x07 with parity bit 1 -> vld, parity_err=0.
//     The same byte with parity bit 0 -> parity_err=1, rdata=0x07.
//  3. 7O2: 0x41; second stop bit driven 0 -> vld, frame_err=1.
//     Then hold rx high -> busy falls, the next frame 0x12 is received cleanly.
//  4. False start: rx low for 6 clk, then high -> busy pulses, FSM back to IDLE, no vld.
//     A 1-clk low glitch inside a data bit of 0xFF -> rdata=0xFF.
//  5. Break: rx low for 20 bit times -> exactly one vld, rdata=0x00, frame_err=1.
//     No further vld until rx returns high and a new start arrives.
//  6. Rate skew: bit period +/-3% (31/33 clk) for 0xC9, 9N1 0x1AB -> correct rdata, no errs.
//     Assert nrst low during bit 4 -> no vld, outputs 0, the next frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receiver and its companion blocks.
//   - parity mode encodings used by the PARITY parameter
//   - receiver FSM state encoding
//   - majority3 vote helper for oversampled bit decisions
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running oversample tick generator.
//   Counts 0..DIV-1 and asserts tick for one clk when the count is DIV-1.
//   A clear forces the count back to 0 so the tick phase can be aligned
//   to an external event (the start-bit falling edge for the receiver).
// Ports:
//   clk    in  system clock
//   nrst   in  asynchronous active-low reset
//   clear  in  synchronous restart of the count
//   tick   out one-clk pulse every DIV clks
module uart_baud_tick #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (clear || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clear && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with oversampled majority voting.
//   rx is synchronised, start-bit aligned, and each bit is decided from three
//   samples around the bit centre. Frames are delivered even when erroneous;
//   parity_err / frame_err are flags qualified by vld.
// Ports:
//   clk         in  system clock
//   nrst        in  asynchronous active-low reset
//   rx          in  serial line, idle high, asynchronous to clk
//   rdata       out received word, holds until the next vld
//   vld         out one-clk pulse per completed frame
//   parity_err  out parity mismatch, qualified by vld
//   frame_err   out a stop bit was sampled low, qualified by vld
//   busy        out high from start detect until return to IDLE
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line idle, waiting for synchronised rx low
// ST_START  | confirming the start bit at its centre (false-start filter)
// ST_DATA   | shifting DATA_BITS payload bits, LSB first
// ST_PARITY | checking the parity bit against the received payload
// ST_STOP   | sampling STOP_BITS stop bits, delivering the word
// ST_BREAK  | line held low after the frame, waiting for rx high
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int FREQ        = 50_000_000,
  parameter int BAUDRATE    = 115200,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 vld,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int DIV   = FREQ / (BAUDRATE * OVERSAMPLE);
  localparam int SUB_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [SUB_W-1:0] SUB_S0   = SUB_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SUB_W-1:0] SUB_S1   = SUB_W'(OVERSAMPLE / 2);
  localparam logic [SUB_W-1:0] SUB_DEC  = SUB_W'(OVERSAMPLE / 2 + 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  if (DIV < 2) begin : g_div_chk
    $error("uart_rx_cfg: FREQ/(BAUDRATE*OVERSAMPLE) must be >= 2");
  end
  if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_os_chk
    $error("uart_rx_cfg: OVERSAMPLE must be even and >= 8");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_db_chk
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_sb_chk
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end
  if (SYNC_STAGES < 2) begin : g_sync_chk
    $error("uart_rx_cfg: SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic                   tick;
  logic                   start_det;
  logic                   dec;
  logic                   voted;
  logic                   par_exp;

  rx_state_e              state;
  logic [SUB_W-1:0]       sub_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic                   s0;
  logic                   s1;
  logic [DATA_BITS-1:0]   rdata_sh;
  logic                   perr;
  logic                   ferr;

  // Synchroniser resets to the idle level so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s      = sync[SYNC_STAGES-1];
  assign start_det = (state == ST_IDLE) && !rx_s;
  assign dec       = tick && (sub_cnt == SUB_DEC);
  // The third vote is taken live at the decision tick.
  assign voted     = majority3(s0, s1, rx_s);
  assign par_exp   = (PARITY == PAR_ODD) ? ~^rdata_sh : ^rdata_sh;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk   (clk),
    .nrst  (nrst),
    .clear (start_det),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= ST_IDLE;
      sub_cnt    <= '0;
      bit_cnt    <= '0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      rdata_sh   <= '0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      rdata      <= '0;
      vld        <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      vld <= 1'b0;

      if (tick && (state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP})) begin
        sub_cnt <= (sub_cnt == SUB_LAST) ? '0 : sub_cnt + 1'b1;
        if (sub_cnt == SUB_S0) s0 <= rx_s;
        if (sub_cnt == SUB_S1) s1 <= rx_s;
      end

      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state   <= ST_START;
            busy    <= 1'b1;
            sub_cnt <= '0;
            bit_cnt <= '0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
          end
        end

        ST_START: begin
          if (dec) begin
            if (!voted) begin
              state <= ST_DATA;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end

        ST_DATA: begin
          if (dec) begin
            // Right shift in LSB-first order: after DATA_BITS shifts bit 0 lands at [0].
            rdata_sh <= {voted, rdata_sh[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        ST_PARITY: begin
          if (dec) begin
            perr  <= (voted != par_exp);
            state <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (dec) begin
            if (!voted) ferr <= 1'b1;
            if (bit_cnt == STOP_LAST) begin
              // Leave at the decision, not the bit end, to absorb baud mismatch.
              vld        <= 1'b1;
              rdata      <= rdata_sh;
              parity_err <= perr;
              frame_err  <= ferr | ~voted;
              bit_cnt    <= '0;
              if (voted) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end else begin
                state <= ST_BREAK;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        ST_BREAK: begin
          if (rx_s) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed bench for uart_rx_cfg.
//   Four receivers share clk/nrst, each with its own rx line:
//   u0 8N1, u1 8E1, u2 7O2, u3 9N1. 16 MHz / 500 kbaud / x16 -> 32 clk per bit.
module tb_uart_rx_cfg;

  logic       clk;
  logic       nrst;
  logic [3:0] rx_l;

  logic [7:0] rdata0, rdata1;
  logic [6:0] rdata2;
  logic [8:0] rdata3;
  logic [3:0] vld_w, pe_w, fe_w, busy_w;
  logic [8:0] dat_w [4];

  int passed = 0;
  int total  = 0;

  int         vcnt [4];
  int         wide [4];
  logic       prev_vld [4];
  logic [8:0] hist_d  [4][32];
  logic       hist_pe [4][32];
  logic       hist_fe [4][32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_rx_cfg #(.FREQ(16_000_000), .BAUDRATE(500_000), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) u0 (
    .clk(clk), .nrst(nrst), .rx(rx_l[0]), .rdata(rdata0), .vld(vld_w[0]),
    .parity_err(pe_w[0]), .frame_err(fe_w[0]), .busy(busy_w[0]));

  uart_rx_cfg #(.FREQ(16_000_000), .BAUDRATE(500_000), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)) u1 (
    .clk(clk), .nrst(nrst), .rx(rx_l[1]), .rdata(rdata1), .vld(vld_w[1]),
    .parity_err(pe_w[1]), .frame_err(fe_w[1]), .busy(busy_w[1]));

  uart_rx_cfg #(.FREQ(16_000_000), .BAUDRATE(500_000), .OVERSAMPLE(16),
                .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .SYNC_STAGES(2)) u2 (
    .clk(clk), .nrst(nrst), .rx(rx_l[2]), .rdata(rdata2), .vld(vld_w[2]),
    .parity_err(pe_w[2]), .frame_err(fe_w[2]), .busy(busy_w[2]));

  uart_rx_cfg #(.FREQ(16_000_000), .BAUDRATE(500_000), .OVERSAMPLE(16),
                .DATA_BITS(9), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) u3 (
    .clk(clk), .nrst(nrst), .rx(rx_l[3]), .rdata(rdata3), .vld(vld_w[3]),
    .parity_err(pe_w[3]), .frame_err(fe_w[3]), .busy(busy_w[3]));

  assign dat_w[0] = {1'b0, rdata0};
  assign dat_w[1] = {1'b0, rdata1};
  assign dat_w[2] = {2'b00, rdata2};
  assign dat_w[3] = rdata3;

  initial begin
    for (int i = 0; i < 4; i++) begin
      vcnt[i]     = 0;
      wide[i]     = 0;
      prev_vld[i] = 1'b0;
    end
  end

  // Frame monitor: record every delivered word, count back-to-back vld highs.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (vld_w[i] === 1'b1) begin
        hist_d[i][vcnt[i] % 32]  <= dat_w[i];
        hist_pe[i][vcnt[i] % 32] <= pe_w[i];
        hist_fe[i][vcnt[i] % 32] <= fe_w[i];
        vcnt[i] <= vcnt[i] + 1;
        if (prev_vld[i]) wide[i] <= wide[i] + 1;
      end
      prev_vld[i] <= (vld_w[i] === 1'b1);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, need finish before 3000000");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input int idx, input logic val, input int period,
                           input logic glitch, input int goff);
    for (int c = 0; c < period; c++) begin
      @(negedge clk);
      rx_l[idx] = (glitch && (c == goff)) ? ~val : val;
    end
  endtask

  // Line order: start 0, data LSB first, optional parity, stop bits; then idle high.
  task automatic send_frame(input int idx, input logic [8:0] data, input int dbits,
                            input int has_par, input logic pbit, input int nstop,
                            input logic [1:0] stopv, input int period,
                            input int gbit, input int goff);
    drive_bit(idx, 1'b0, period, 1'b0, 0);
    for (int b = 0; b < dbits; b++)
      drive_bit(idx, data[b], period, (b == gbit), goff);
    if (has_par != 0) drive_bit(idx, pbit, period, 1'b0, 0);
    for (int s = 0; s < nstop; s++) drive_bit(idx, stopv[s], period, 1'b0, 0);
    @(negedge clk);
    rx_l[idx] = 1'b1;
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    rx_l = 4'hF;
    idle(5);
    total++; if (vld_w !== 4'h0) $display("FAIL reset_vld: got %b need 0000", vld_w); else passed++;
    total++; if (busy_w !== 4'h0) $display("FAIL reset_busy: got %b need 0000", busy_w); else passed++;
    total++; if (pe_w !== 4'h0 || fe_w !== 4'h0) $display("FAIL reset_errs: got pe=%b fe=%b need 0000", pe_w, fe_w); else passed++;
    total++; if (rdata0 !== 8'h00 || rdata3 !== 9'h000) $display("FAIL reset_rdata: got %h/%h need 00/000", rdata0, rdata3); else passed++;
    nrst = 1'b1;
    idle(10);
    total++; if (busy_w !== 4'h0) $display("FAIL idle_busy: got %b need 0000", busy_w); else passed++;
  endtask

  task automatic test_back_to_back;
    int b;
    b = vcnt[0];
    send_frame(0, 9'h055, 8, 0, 1'b0, 1, 2'b11, 32, -1, 0);
    send_frame(0, 9'h0A3, 8, 0, 1'b0, 1, 2'b11, 32, -1, 0);
    idle(8);
    total++; if (vcnt[0] !== b + 2) $display("FAIL b2b_count: got %0d need %0d", vcnt[0] - b, 2); else passed++;
    total++; if (hist_d[0][b % 32] !== 9'h055) $display("FAIL b2b_first: got %h need 055", hist_d[0][b % 32]); else passed++;
    total++; if (hist_d[0][(b + 1) % 32] !== 9'h0A3) $display("FAIL b2b_second: got %h need 0a3", hist_d[0][(b + 1) % 32]); else passed++;
    total++; if (hist_pe[0][b % 32] !== 1'b0 || hist_fe[0][b % 32] !== 1'b0 ||
                 hist_pe[0][(b + 1) % 32] !== 1'b0 || hist_fe[0][(b + 1) % 32] !== 1'b0)
      $display("FAIL b2b_errs: got pe=%b%b fe=%b%b need 00/00", hist_pe[0][b % 32],
               hist_pe[0][(b + 1) % 32], hist_fe[0][b % 32], hist_fe[0][(b + 1) % 32]);
    else passed++;
    total++; if (rdata0 !== 8'hA3) $display("FAIL rdata_hold: got %h need a3", rdata0); else passed++;
  endtask

  task automatic test_even_parity;
    int b;
    b = vcnt[1];
    // 0x07 has three ones, so even parity bit is 1.
    send_frame(1, 9'h007, 8, 1, 1'b1, 1, 2'b11, 32, -1, 0);
    idle(8);
    send_frame(1, 9'h007, 8, 1, 1'b0, 1, 2'b11, 32, -1, 0);
    idle(8);
    total++; if (vcnt[1] !== b + 2) $display("FAIL 8e1_count: got %0d need 2", vcnt[1] - b); else passed++;
    total++; if (hist_pe[1][b % 32] !== 1'b0) $display("FAIL 8e1_good_pe: got %b need 0", hist_pe[1][b % 32]); else passed++;
    total++; if (hist_pe[1][(b + 1) % 32] !== 1'b1) $display("FAIL 8e1_bad_pe: got %b need 1", hist_pe[1][(b + 1) % 32]); else passed++;
    total++; if (hist_d[1][(b + 1) % 32] !== 9'h007) $display("FAIL 8e1_bad_data: got %h need 007", hist_d[1][(b + 1) % 32]); else passed++;
    total++; if (hist_fe[1][(b + 1) % 32] !== 1'b0) $display("FAIL 8e1_fe: got %b need 0", hist_fe[1][(b + 1) % 32]); else passed++;
  endtask

  task automatic test_framing;
    int b;
    b = vcnt[2];
    // 7-bit 0x41 has two ones -> odd parity bit 1. Second stop bit low.
    send_frame(2, 9'h041, 7, 1, 1'b1, 2, 2'b01, 32, -1, 0);
    total++; if (busy_w[2] !== 1'b1) $display("FAIL 7o2_break_busy: got %b need 1", busy_w[2]); else passed++;
    idle(10);
    total++; if (busy_w[2] !== 1'b0) $display("FAIL 7o2_busy_fall: got %b need 0", busy_w[2]); else passed++;
    total++; if (vcnt[2] !== b + 1) $display("FAIL 7o2_count: got %0d need 1", vcnt[2] - b); else passed++;
    total++; if (hist_d[2][b % 32] !== 9'h041 || hist_fe[2][b % 32] !== 1'b1 || hist_pe[2][b % 32] !== 1'b0)
      $display("FAIL 7o2_frame_err: got d=%h fe=%b pe=%b need 041/1/0", hist_d[2][b % 32], hist_fe[2][b % 32], hist_pe[2][b % 32]);
    else passed++;
    // 7-bit 0x12 has two ones -> odd parity bit 1.
    send_frame(2, 9'h012, 7, 1, 1'b1, 2, 2'b11, 32, -1, 0);
    idle(8);
    total++; if (vcnt[2] !== b + 2) $display("FAIL 7o2_next_count: got %0d need 2", vcnt[2] - b); else passed++;
    total++; if (hist_d[2][(b + 1) % 32] !== 9'h012 || hist_fe[2][(b + 1) % 32] !== 1'b0 || hist_pe[2][(b + 1) % 32] !== 1'b0)
      $display("FAIL 7o2_next: got d=%h fe=%b pe=%b need 012/0/0", hist_d[2][(b + 1) % 32], hist_fe[2][(b + 1) % 32], hist_pe[2][(b + 1) % 32]);
    else passed++;
  endtask

  task automatic test_false_start;
    int   b;
    logic seen;
    b    = vcnt[0];
    seen = 1'b0;
    @(negedge clk); rx_l[0] = 1'b0;
    idle(6);
    rx_l[0] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy_w[0] === 1'b1) seen = 1'b1;
    end
    total++; if (seen !== 1'b1) $display("FAIL fs_busy_pulse: got %b need 1", seen); else passed++;
    total++; if (busy_w[0] !== 1'b0) $display("FAIL fs_back_idle: got %b need 0", busy_w[0]); else passed++;
    total++; if (vcnt[0] !== b) $display("FAIL fs_no_vld: got %0d need 0", vcnt[0] - b); else passed++;
    send_frame(0, 9'h0FF, 8, 0, 1'b0, 1, 2'b11, 32, 3, 19);
    idle(8);
    total++; if (vcnt[0] !== b + 1) $display("FAIL glitch_count: got %0d need 1", vcnt[0] - b); else passed++;
    total++; if (hist_d[0][b % 32] !== 9'h0FF || hist_fe[0][b % 32] !== 1'b0)
      $display("FAIL glitch_data: got d=%h fe=%b need 0ff/0", hist_d[0][b % 32], hist_fe[0][b % 32]);
    else passed++;
  endtask

  task automatic test_break;
    int b;
    b = vcnt[0];
    @(negedge clk); rx_l[0] = 1'b0;
    idle(20 * 32);
    total++; if (vcnt[0] !== b + 1) $display("FAIL brk_count: got %0d need 1", vcnt[0] - b); else passed++;
    total++; if (hist_d[0][b % 32] !== 9'h000 || hist_fe[0][b % 32] !== 1'b1)
      $display("FAIL brk_frame: got d=%h fe=%b need 000/1", hist_d[0][b % 32], hist_fe[0][b % 32]);
    else passed++;
    total++; if (busy_w[0] !== 1'b1) $display("FAIL brk_busy: got %b need 1", busy_w[0]); else passed++;
    rx_l[0] = 1'b1;
    idle(64);
    total++; if (vcnt[0] !== b + 1 || busy_w[0] !== 1'b0)
      $display("FAIL brk_release: got count=%0d busy=%b need 1/0", vcnt[0] - b, busy_w[0]);
    else passed++;
    send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 2'b11, 32, -1, 0);
    idle(8);
    total++; if (vcnt[0] !== b + 2 || hist_d[0][(b + 1) % 32] !== 9'h03C)
      $display("FAIL brk_next: got count=%0d d=%h need 2/03c", vcnt[0] - b, hist_d[0][(b + 1) % 32]);
    else passed++;
  endtask

  task automatic test_rate_skew;
    int b0, b3;
    b0 = vcnt[0];
    b3 = vcnt[3];
    send_frame(0, 9'h0C9, 8, 0, 1'b0, 1, 2'b11, 33, -1, 0);
    idle(8);
    send_frame(0, 9'h0C9, 8, 0, 1'b0, 1, 2'b11, 31, -1, 0);
    idle(8);
    send_frame(3, 9'h1AB, 9, 0, 1'b0, 1, 2'b11, 33, -1, 0);
    idle(8);
    send_frame(3, 9'h1AB, 9, 0, 1'b0, 1, 2'b11, 31, -1, 0);
    idle(8);
    total++; if (vcnt[0] !== b0 + 2 || vcnt[3] !== b3 + 2)
      $display("FAIL skew_count: got %0d/%0d need 2/2", vcnt[0] - b0, vcnt[3] - b3);
    else passed++;
    total++; if (hist_d[0][b0 % 32] !== 9'h0C9 || hist_fe[0][b0 % 32] !== 1'b0)
      $display("FAIL skew_slow_8: got d=%h fe=%b need 0c9/0", hist_d[0][b0 % 32], hist_fe[0][b0 % 32]);
    else passed++;
    total++; if (hist_d[0][(b0 + 1) % 32] !== 9'h0C9 || hist_fe[0][(b0 + 1) % 32] !== 1'b0)
      $display("FAIL skew_fast_8: got d=%h fe=%b need 0c9/0", hist_d[0][(b0 + 1) % 32], hist_fe[0][(b0 + 1) % 32]);
    else passed++;
    total++; if (hist_d[3][b3 % 32] !== 9'h1AB || hist_fe[3][b3 % 32] !== 1'b0)
      $display("FAIL skew_slow_9: got d=%h fe=%b need 1ab/0", hist_d[3][b3 % 32], hist_fe[3][b3 % 32]);
    else passed++;
    total++; if (hist_d[3][(b3 + 1) % 32] !== 9'h1AB || hist_fe[3][(b3 + 1) % 32] !== 1'b0 || hist_pe[3][(b3 + 1) % 32] !== 1'b0)
      $display("FAIL skew_fast_9: got d=%h fe=%b pe=%b need 1ab/0/0", hist_d[3][(b3 + 1) % 32], hist_fe[3][(b3 + 1) % 32], hist_pe[3][(b3 + 1) % 32]);
    else passed++;
  endtask

  task automatic test_reset_midframe;
    int b;
    b = vcnt[0];
    // 0xF0: bits 4..7 and stop are high, so the line stays idle after the abort.
    fork
      send_frame(0, 9'h0F0, 8, 0, 1'b0, 1, 2'b11, 32, -1, 0);
      begin
        idle(5 * 32 + 8);
        total++; if (busy_w[0] !== 1'b1) $display("FAIL rst_mid_busy_before: got %b need 1", busy_w[0]); else passed++;
        nrst = 1'b0;
        idle(2);
        total++; if (busy_w[0] !== 1'b0 || vld_w[0] !== 1'b0 || rdata0 !== 8'h00 || pe_w[0] !== 1'b0 || fe_w[0] !== 1'b0)
          $display("FAIL rst_mid_outputs: got busy=%b vld=%b d=%h pe=%b fe=%b need 0/0/00/0/0",
                   busy_w[0], vld_w[0], rdata0, pe_w[0], fe_w[0]);
        else passed++;
        nrst = 1'b1;
      end
    join
    idle(40);
    total++; if (vcnt[0] !== b) $display("FAIL rst_mid_no_vld: got %0d need 0", vcnt[0] - b); else passed++;
    send_frame(0, 9'h096, 8, 0, 1'b0, 1, 2'b11, 32, -1, 0);
    idle(8);
    total++; if (vcnt[0] !== b + 1 || hist_d[0][b % 32] !== 9'h096 || hist_fe[0][b % 32] !== 1'b0)
      $display("FAIL rst_mid_next: got count=%0d d=%h fe=%b need 1/096/0", vcnt[0] - b, hist_d[0][b % 32], hist_fe[0][b % 32]);
    else passed++;
  endtask

  task automatic test_vld_width;
    total++; if ((wide[0] + wide[1] + wide[2] + wide[3]) !== 0)
      $display("FAIL vld_width: got %0d multi-clk pulses need 0", wide[0] + wide[1] + wide[2] + wide[3]);
    else passed++;
  endtask

  initial begin
    nrst = 1'b0;
    rx_l = 4'hF;
    test_reset;
    test_back_to_back;
    test_even_parity;
    test_framing;
    test_false_start;
    test_break;
    test_rate_skew;
    test_reset_midframe;
    test_vld_width;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
